// File: rtl/ram_dma.sv
// ram_dma: block fill / block copy initiator for the 8-bit RAM.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; RAM port strobes low
// RD    | copy only: read strobe at src+i
// LAT   | RAM read latency; ram_out is captured into ram_data at exit
// WR    | write strobe at dst+i; i and count advance at exit
// FIN   | one-cycle done pulse, then back to IDLE
module ram_dma #(
    parameter int AW = 8,
    parameter int DW = 8,
    parameter int LW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [LW-1:0] len,
    input  logic [DW-1:0] fill_value,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [LW-1:0] count,
    output logic          ram_read,
    output logic          ram_write,
    output logic [AW-1:0] ram_address,
    output logic [DW-1:0] ram_data,
    input  logic [DW-1:0] ram_out
);

    typedef enum logic [2:0] {IDLE, RD, LAT, WR, FIN} state_t;

    state_t        state;
    logic          mode_r;
    logic [AW-1:0] src_r;
    logic [AW-1:0] dst_r;
    logic [LW-1:0] len_r;
    logic [DW-1:0] fill_r;
    logic [LW-1:0] idx;
    logic [LW-1:0] idx_nxt;

    assign idx_nxt = idx + LW'(1);

    // Sequencer: all outputs are registered. In copy mode ram_data itself
    // serves as the data buffer, loaded from ram_out on the LAT->WR edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            mode_r      <= 1'b0;
            src_r       <= '0;
            dst_r       <= '0;
            len_r       <= '0;
            fill_r      <= '0;
            idx         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            count       <= '0;
            ram_read    <= 1'b0;
            ram_write   <= 1'b0;
            ram_address <= '0;
            ram_data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    // abort in the same cycle drops the start
                    if (start && !abort) begin
                        count <= '0;
                        idx   <= '0;
                        if (len == '0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            mode_r <= mode;
                            src_r  <= src;
                            dst_r  <= dst;
                            len_r  <= len;
                            fill_r <= fill_value;
                            busy   <= 1'b1;
                            if (mode) begin
                                state       <= RD;
                                ram_read    <= 1'b1;
                                ram_address <= src;
                            end else begin
                                state       <= WR;
                                ram_write   <= 1'b1;
                                ram_address <= dst;
                                ram_data    <= fill_value;
                            end
                        end
                    end
                end
                RD: begin
                    ram_read <= 1'b0;
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= LAT;
                    end
                end
                LAT: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state       <= WR;
                        ram_write   <= 1'b1;
                        ram_address <= dst_r + AW'(idx);
                        ram_data    <= ram_out;
                    end
                end
                WR: begin
                    // the write strobed this cycle always lands, so count it
                    count     <= count + LW'(1);
                    idx       <= idx_nxt;
                    ram_write <= 1'b0;
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (idx_nxt == len_r) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (mode_r) begin
                        state       <= RD;
                        ram_read    <= 1'b1;
                        ram_address <= src_r + AW'(idx_nxt);
                    end else begin
                        ram_write   <= 1'b1;
                        ram_address <= dst_r + AW'(idx_nxt);
                        ram_data    <= fill_r;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    ram_read  <= 1'b0;
                    ram_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ram_dma.md
Name: ram_dma

Overview:
- Bus initiator for the 8-bit RAM. It fills or copies blocks of RAM without CPU involvement.
- It drives the RAM's read/write/address/data inputs and consumes the RAM's registered data output.
- It sits between the control sequencer, which issues start/mode/len, and the RAM, and owns the RAM port while busy.

Parameters:
- AW, 8, address width (RAM address bus and src/dst width)
- DW, 8, data width (RAM data/out width)
- LW, 8, length/count width

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  command strobe, sampled only in IDLE
- mode  input  1  0 = fill, 1 = copy; latched at start
- src  input  AW  copy source base; latched at start
- dst  input  AW  destination base; latched at start
- len  input  LW  byte count; latched at start
- fill_value  input  DW  fill byte; latched at start
- abort  input  1  terminate the current operation
- busy  output  1  operation in progress
- done  output  1  one-cycle completion pulse
- count  output  LW  bytes written in the current/last operation
- ram_read  output  1  RAM read strobe
- ram_write  output  1  RAM write strobe
- ram_address  output  AW  RAM address
- ram_data  output  DW  RAM write data
- ram_out  input  DW  RAM read data; registered, valid the cycle after ram_read is sampled, held until the next read

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (rst).
- Outputs: all outputs are registered.
- Reset values: busy=0, done=0, count=0, ram_read=0, ram_write=0, ram_address=0, ram_data=0. The FSM goes to IDLE and the internal index is 0.
- FSM states: IDLE, RD, LAT, WR, FIN.
- IDLE:
  - start=1 and len=0: go to FIN. No RAM access; count reset to 0.
  - start=1 and len!=0: latch the inputs, set count=0 and index i=0, set busy=1. Go to RD if mode=1, else go to WR.
- RD (copy only): ram_read=1, ram_address=src+i. Next state is LAT.
- LAT: strobes are 0. At the end of the cycle, capture ram_out into the data buffer. Next state is WR.
- WR: ram_write=1, ram_address=dst+i. ram_data is the data buffer in copy mode and fill_value in fill mode. At the edge, count and i increment.
  - If i+1 == len, go to FIN.
  - Otherwise go to RD (copy) or stay in WR (fill).
- FIN: busy=0 and done=1 for exactly one cycle. Next state is IDLE.
- Throughput: fill is 1 cycle/byte; copy is 3 cycles/byte.
- Timing: with start sampled at edge T0, the first strobe is high in the cycle after T0. For a fill of N bytes, writes occupy cycles 1..N and done is high in cycle N+1. For a copy of N bytes, done is high in cycle 3N+1.
- Address arithmetic: src+i and dst+i are modulo 2^AW and wrap 0xFF→0x00 without error.
- Overlapping copy: copy is strictly ascending, with no overlap handling. If dst is in (src, src+len), source bytes are overwritten before they are read, which propagates the pattern. This is the decided behaviour.
- start while busy, or while in FIN: ignored, and the latched parameters are not altered.
- abort while busy:
  - At the next edge go to IDLE and force strobes to 0; busy=0 and done is not pulsed.
  - count holds the number of completed writes.
  - A write strobed in the same cycle as abort still completes.
- abort in IDLE: no effect.
- start and abort in the same IDLE cycle: abort wins and start is dropped.
- Mid-operation reset: outputs return to their reset values immediately (asynchronously), with no done pulse. RAM contents written so far are unaffected.
- Strobe exclusivity: ram_read and ram_write are never high in the same cycle. Outside RD/WR, ram_address and ram_data hold their last values.

Test Plan:
- Fill: reset, then start with mode=0, dst=0x10, len=4, fill_value=0xAA. Required: writes to 0x10..0x13 on 4 consecutive cycles, done in cycle 5, count=4. RAM reads back 0xAA at each address.
- Copy: preload RAM 0x01=0x11, 0x02=0x22, 0x03=0x33, then start with mode=1, src=0x01, dst=0x20, len=3. Required: RD/LAT/WR pattern, done in cycle 10, and RAM 0x20..0x22 = 0x11/0x22/0x33.
- Wrap: fill with dst=0xFE, len=3, fill_value=0xCC. Required: writes at 0xFE, 0xFF, 0x00 and count=3.
- Zero length: start with len=0. Required: no ram_read/ram_write, done pulses in the next cycle, busy stays 0, count=0.
- Abort and restart: copy with len=8, assert abort after the 2nd write. Required: busy falls, no done, count=2, strobes 0. A second start with len=1 completes normally with done.
- Reset mid-op, and start ignored while busy: pulse rst during a fill. Required: all outputs 0 immediately. Restart, and a start pulse during busy does not change dst or len.
